// File: rtl/mem_access_ctrl_if.sv
// Data-side SRAM-like bus: request/address-ok/data-ok handshake between the MEM stage and data memory.
interface mem_access_ctrl_if;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: issues one bus transaction per op, stalls the pipeline while it is
// in flight, tracks the LL/SC link bit and flags misaligned addresses.
module mem_access_ctrl (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               mem_op,
  input  logic [31:0]              ALU_result,
  input  logic [31:0]              rf_rdata1_fw,
  input  logic                     MEM_Flush,
  input  logic                     llbit_clr,
  input  logic                     MEM_WB_Stall,
  mem_access_ctrl_if.master        bus,
  output logic                     mem_stall,
  output logic [31:0]              mem_rdata,
  output logic [3:0]               byte_valid,
  output logic                     SC_result_sel,
  output logic                     adel,
  output logic                     ades
);
  localparam logic [3:0] OP_LB  = 4'd1,  OP_LBU = 4'd2,  OP_LH  = 4'd3,  OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5,  OP_LWL = 4'd6,  OP_LWR = 4'd7,  OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9,  OP_SW  = 4'd10, OP_SWL = 4'd11, OP_SWR = 4'd12;
  localparam logic [3:0] OP_LL  = 4'd13, OP_SC  = 4'd14;

  typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA, DONE} state_t;

  state_t      state_reg, state_next;
  logic        llbit_reg, llbit_next;
  logic        discard_reg, discard_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [31:0] addr_reg, wdata_reg;
  logic [3:0]  wstrb_reg;
  logic        wr_reg, ll_reg, sc_reg;

  logic [1:0]  a;
  logic        is_load, is_store, fault;
  logic [3:0]  pattern;
  logic [31:0] wdata_comb;
  logic        is_ll, is_sc, sc_ok, sc_fail, op_active, go, resp, issue;

  assign a = ALU_result[1:0];

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    fault      = 1'b0;
    pattern    = 4'b0000;
    wdata_comb = 32'd0;
    case (mem_op)
      OP_LB, OP_LBU: begin is_load = 1'b1; pattern = 4'b0001 << a; end
      OP_LH, OP_LHU: begin is_load = 1'b1; fault = a[0]; pattern = a[1] ? 4'b1100 : 4'b0011; end
      OP_LW, OP_LL:  begin is_load = 1'b1; fault = |a; pattern = 4'b1111; end
      OP_LWL:        begin is_load = 1'b1; pattern = 4'b1111 >> (2'd3 - a); end
      OP_LWR:        begin is_load = 1'b1; pattern = 4'b1111 << a; end
      OP_SB: begin
        is_store = 1'b1; pattern = 4'b0001 << a; wdata_comb = {4{rf_rdata1_fw[7:0]}};
      end
      OP_SH: begin
        is_store = 1'b1; fault = a[0]; pattern = a[1] ? 4'b1100 : 4'b0011;
        wdata_comb = {2{rf_rdata1_fw[15:0]}};
      end
      OP_SW, OP_SC: begin
        is_store = 1'b1; fault = |a; pattern = 4'b1111; wdata_comb = rf_rdata1_fw;
      end
      OP_SWL: begin
        is_store = 1'b1; pattern = 4'b1111 >> (2'd3 - a);
        wdata_comb = rf_rdata1_fw >> (5'd24 - {a, 3'b000});
      end
      OP_SWR: begin
        is_store = 1'b1; pattern = 4'b1111 << a; wdata_comb = rf_rdata1_fw << {a, 3'b000};
      end
      default: ;
    endcase
  end

  assign is_ll = (mem_op == OP_LL);
  assign is_sc = (mem_op == OP_SC);
  // Once an SC is on the bus its outcome is fixed; only an SC still waiting in IDLE (or behind a drain) consults the link bit.
  assign sc_ok         = (state_reg == IDLE || discard_reg) ? llbit_reg : sc_reg;
  assign sc_fail       = is_sc & ~sc_ok;
  assign op_active     = (is_load | is_store) & ~MEM_Flush;
  assign go            = op_active & ~fault & ~sc_fail;
  assign resp          = (state_reg == WAIT_DATA) & bus.data_data_ok & ~discard_reg;
  assign adel          = is_load & fault;
  assign ades          = is_store & fault;
  assign byte_valid    = pattern;
  assign SC_result_sel = is_sc & ~fault & sc_ok;
  assign mem_stall     = op_active & ~fault & ~sc_fail & ~resp & (state_reg != DONE);
  assign mem_rdata     = resp ? bus.data_rdata : ((state_reg == DONE) ? rdata_reg : 32'd0);

  always_comb begin
    state_next     = state_reg;
    discard_next   = discard_reg;
    rdata_next     = rdata_reg;
    issue          = 1'b0;
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_wstrb = 4'b0000;
    bus.data_addr  = 32'd0;
    bus.data_wdata = 32'd0;
    case (state_reg)
      IDLE: begin
        if (go) begin
          issue          = 1'b1;
          bus.data_req   = 1'b1;
          bus.data_wr    = is_store;
          bus.data_wstrb = is_store ? pattern : 4'b0000;
          bus.data_addr  = {ALU_result[31:2], 2'b00};
          bus.data_wdata = wdata_comb;
          state_next     = bus.data_addr_ok ? WAIT_DATA : WAIT_ADDR;
        end
      end
      WAIT_ADDR: begin
        if (MEM_Flush) begin
          state_next = IDLE;
        end else begin
          bus.data_req   = 1'b1;
          bus.data_wr    = wr_reg;
          bus.data_wstrb = wstrb_reg;
          bus.data_addr  = addr_reg;
          bus.data_wdata = wdata_reg;
          if (bus.data_addr_ok) state_next = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (bus.data_data_ok) begin
          discard_next = 1'b0;
          if (!discard_reg && !MEM_Flush && MEM_WB_Stall) begin
            state_next = DONE;
            rdata_next = bus.data_rdata;
          end else begin
            state_next = IDLE;
          end
        end else if (MEM_Flush) begin
          discard_next = 1'b1;
        end
      end
      DONE: begin
        if (!MEM_WB_Stall) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    llbit_next = llbit_reg;
    if (llbit_clr)                         llbit_next = 1'b0;
    else if (resp && sc_reg)               llbit_next = 1'b0;
    else if (resp && ll_reg && !MEM_Flush) llbit_next = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      llbit_reg   <= 1'b0;
      discard_reg <= 1'b0;
      rdata_reg   <= 32'd0;
      addr_reg    <= 32'd0;
      wdata_reg   <= 32'd0;
      wstrb_reg   <= 4'b0000;
      wr_reg      <= 1'b0;
      ll_reg      <= 1'b0;
      sc_reg      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      llbit_reg   <= llbit_next;
      discard_reg <= discard_next;
      rdata_reg   <= rdata_next;
      if (issue) begin
        addr_reg  <= bus.data_addr;
        wdata_reg <= bus.data_wdata;
        wstrb_reg <= bus.data_wstrb;
        wr_reg    <= bus.data_wr;
        ll_reg    <= is_ll;
        sc_reg    <= is_sc;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: the bench plays the data SRAM bus by hand, cycle by cycle.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mem_op;
  logic [31:0] alu, rt;
  logic        flush, llclr, wbstall;
  logic        mem_stall, sc_sel, adel, ades;
  logic [31:0] mem_rdata;
  logic [3:0]  byte_valid;
  int          vectors = 0;
  int          miscompares = 0;

  mem_access_ctrl_if bus();

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_op(mem_op), .ALU_result(alu), .rf_rdata1_fw(rt),
    .MEM_Flush(flush), .llbit_clr(llclr), .MEM_WB_Stall(wbstall), .bus(bus),
    .mem_stall(mem_stall), .mem_rdata(mem_rdata), .byte_valid(byte_valid),
    .SC_result_sel(sc_sel), .adel(adel), .ades(ades)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_op = 4'd0; alu = 32'd0; rt = 32'd0; flush = 1'b0; llclr = 1'b0; wbstall = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b need 0", bus.data_req); end
    vectors++; if (mem_stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b need 0", mem_stall); end
    vectors++; if (mem_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_rdata: got %h need 0", mem_rdata); end
    vectors++; if ({byte_valid, sc_sel, adel, ades} !== 7'd0) begin miscompares++; $display("FAIL reset_misc: got %b need 0", {byte_valid, sc_sel, adel, ades}); end
    vectors++; if (bus.data_addr !== 32'd0 || bus.data_wstrb !== 4'd0) begin miscompares++; $display("FAIL reset_bus: got %h/%b need 0/0", bus.data_addr, bus.data_wstrb); end
    cyc();
    rst_n = 1'b1;
    cyc();
    $display("reset: outputs idle");
  endtask

  task automatic test_lw();
    mem_op = 4'd5; alu = 32'h1000; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b1 || bus.data_wr !== 1'b0) begin miscompares++; $display("FAIL lw_req: got req=%b wr=%b need 1/0", bus.data_req, bus.data_wr); end
    vectors++; if (bus.data_addr !== 32'h1000 || bus.data_wstrb !== 4'b0000) begin miscompares++; $display("FAIL lw_addr: got %h/%b need 1000/0000", bus.data_addr, bus.data_wstrb); end
    vectors++; if (mem_stall !== 1'b1) begin miscompares++; $display("FAIL lw_stall_c0: got %b need 1", mem_stall); end
    cyc();
    bus.data_addr_ok = 1'b0;
    @(negedge clk);
    vectors++; if (mem_stall !== 1'b1 || bus.data_req !== 1'b0) begin miscompares++; $display("FAIL lw_c1: got stall=%b req=%b need 1/0", mem_stall, bus.data_req); end
    cyc();
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEADBEEF;
    @(negedge clk);
    vectors++; if (mem_stall !== 1'b0) begin miscompares++; $display("FAIL lw_stall_c2: got %b need 0", mem_stall); end
    vectors++; if (mem_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_rdata: got %h need deadbeef", mem_rdata); end
    vectors++; if (byte_valid !== 4'b1111) begin miscompares++; $display("FAIL lw_bv: got %b need 1111", byte_valid); end
    $display("lw 0x1000: rdata=%h", mem_rdata);
    cyc();
    idle_inputs();
    cyc();
  endtask

  task automatic test_store_align();
    mem_op = 4'd8; alu = 32'h2003; rt = 32'h12345678;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b1 || bus.data_wr !== 1'b1) begin miscompares++; $display("FAIL sb_req: got req=%b wr=%b need 1/1", bus.data_req, bus.data_wr); end
    vectors++; if (bus.data_wstrb !== 4'b1000 || bus.data_wdata !== 32'h78787878) begin miscompares++; $display("FAIL sb_data: got %b/%h need 1000/78787878", bus.data_wstrb, bus.data_wdata); end
    vectors++; if (bus.data_addr !== 32'h2000) begin miscompares++; $display("FAIL sb_addr: got %h need 2000", bus.data_addr); end
    cyc();
    bus.data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b1 || bus.data_wstrb !== 4'b1000 || bus.data_addr !== 32'h2000) begin miscompares++; $display("FAIL sb_hold: got %b/%b/%h need 1/1000/2000", bus.data_req, bus.data_wstrb, bus.data_addr); end
    vectors++; if (mem_stall !== 1'b1) begin miscompares++; $display("FAIL sb_stall: got %b need 1", mem_stall); end
    cyc();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
    @(negedge clk);
    vectors++; if (mem_stall !== 1'b0) begin miscompares++; $display("FAIL sb_done: got %b need 0", mem_stall); end
    $display("sb 0x2003: wstrb=1000 wdata=78787878");
    cyc();
    idle_inputs();
    mem_op = 4'd12; alu = 32'h3002; rt = 32'hAABBCCDD; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_wstrb !== 4'b1100 || bus.data_wdata !== 32'hCCDD0000) begin miscompares++; $display("FAIL swr_data: got %b/%h need 1100/ccdd0000", bus.data_wstrb, bus.data_wdata); end
    vectors++; if (byte_valid !== 4'b1100 || bus.data_addr !== 32'h3000) begin miscompares++; $display("FAIL swr_bv: got %b/%h need 1100/3000", byte_valid, bus.data_addr); end
    cyc();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
    cyc();
    $display("swr 0x3002: wstrb=1100 wdata=ccdd0000");
    idle_inputs();
    mem_op = 4'd11; alu = 32'h3001; rt = 32'hAABBCCDD; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_wstrb !== 4'b0011 || bus.data_wdata !== 32'h0000AABB) begin miscompares++; $display("FAIL swl_data: got %b/%h need 0011/0000aabb", bus.data_wstrb, bus.data_wdata); end
    cyc();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
    cyc();
    $display("swl 0x3001: wstrb=0011 wdata=0000aabb");
    idle_inputs();
    cyc();
  endtask

  task automatic test_fault();
    mem_op = 4'd3; alu = 32'h4001; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if (adel !== 1'b1 || ades !== 1'b0) begin miscompares++; $display("FAIL lh_adel: got adel=%b ades=%b need 1/0", adel, ades); end
    vectors++; if (bus.data_req !== 1'b0 || mem_stall !== 1'b0) begin miscompares++; $display("FAIL lh_noreq: got req=%b stall=%b need 0/0", bus.data_req, mem_stall); end
    cyc();
    mem_op = 4'd10; alu = 32'h4002;
    @(negedge clk);
    vectors++; if (ades !== 1'b1 || adel !== 1'b0 || bus.data_req !== 1'b0) begin miscompares++; $display("FAIL sw_ades: got ades=%b adel=%b req=%b need 1/0/0", ades, adel, bus.data_req); end
    cyc();
    mem_op = 4'd7; alu = 32'h4003;
    @(negedge clk);
    vectors++; if (adel !== 1'b0 || bus.data_req !== 1'b1 || byte_valid !== 4'b1000) begin miscompares++; $display("FAIL lwr_ok: got adel=%b req=%b bv=%b need 0/1/1000", adel, bus.data_req, byte_valid); end
    cyc();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
    cyc();
    $display("faults: lh 0x4001 adel, sw 0x4002 ades, lwr 0x4003 issued");
    idle_inputs();
    cyc();
  endtask

  task automatic do_ll(input logic clr_at_done);
    mem_op = 4'd13; alu = 32'h5000; bus.data_addr_ok = 1'b1;
    cyc();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h11; llclr = clr_at_done;
    cyc();
    idle_inputs();
  endtask

  task automatic test_llsc();
    do_ll(1'b0);
    mem_op = 4'd14; alu = 32'h5000; rt = 32'h99; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b1 || sc_sel !== 1'b1) begin miscompares++; $display("FAIL sc_issue: got req=%b sel=%b need 1/1", bus.data_req, sc_sel); end
    vectors++; if (bus.data_wstrb !== 4'b1111 || bus.data_wdata !== 32'h99) begin miscompares++; $display("FAIL sc_data: got %b/%h need 1111/99", bus.data_wstrb, bus.data_wdata); end
    cyc();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
    @(negedge clk);
    vectors++; if (sc_sel !== 1'b1 || mem_stall !== 1'b0) begin miscompares++; $display("FAIL sc_done: got sel=%b stall=%b need 1/0", sc_sel, mem_stall); end
    cyc();
    bus.data_data_ok = 1'b0; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b0 || sc_sel !== 1'b0 || mem_stall !== 1'b0) begin miscompares++; $display("FAIL sc_again: got req=%b sel=%b stall=%b need 0/0/0", bus.data_req, sc_sel, mem_stall); end
    $display("ll/sc: sc succeeded, second sc failed");
    idle_inputs();
    cyc();
    do_ll(1'b0);
    llclr = 1'b1;
    cyc();
    idle_inputs();
    mem_op = 4'd14; alu = 32'h5000; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b0 || sc_sel !== 1'b0) begin miscompares++; $display("FAIL sc_after_clr: got req=%b sel=%b need 0/0", bus.data_req, sc_sel); end
    idle_inputs();
    cyc();
    do_ll(1'b1);
    mem_op = 4'd14; alu = 32'h5000; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b0 || sc_sel !== 1'b0) begin miscompares++; $display("FAIL sc_clr_wins: got req=%b sel=%b need 0/0", bus.data_req, sc_sel); end
    $display("ll/llbit_clr/sc: sc failed without request");
    idle_inputs();
    cyc();
  endtask

  task automatic test_flush();
    mem_op = 4'd5; alu = 32'h6000; bus.data_addr_ok = 1'b1;
    cyc();
    bus.data_addr_ok = 1'b0; flush = 1'b1;
    @(negedge clk);
    vectors++; if (mem_stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall: got %b need 0", mem_stall); end
    cyc();
    flush = 1'b0; alu = 32'h6004; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b0 || mem_stall !== 1'b1) begin miscompares++; $display("FAIL drain_hold: got req=%b stall=%b need 0/1", bus.data_req, mem_stall); end
    cyc();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    vectors++; if (mem_rdata !== 32'd0 || bus.data_req !== 1'b0 || mem_stall !== 1'b1) begin miscompares++; $display("FAIL drain_drop: got %h req=%b stall=%b need 0/0/1", mem_rdata, bus.data_req, mem_stall); end
    cyc();
    bus.data_data_ok = 1'b0; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h6004) begin miscompares++; $display("FAIL drain_next: got req=%b addr=%h need 1/6004", bus.data_req, bus.data_addr); end
    cyc();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h600D;
    @(negedge clk);
    vectors++; if (mem_rdata !== 32'h600D || mem_stall !== 1'b0) begin miscompares++; $display("FAIL drain_lw: got %h stall=%b need 600d/0", mem_rdata, mem_stall); end
    $display("flush in wait_data: old response dropped, lw 0x6004 rdata=%h", mem_rdata);
    cyc();
    idle_inputs();
    mem_op = 4'd10; alu = 32'h6100; rt = 32'h1;
    cyc();
    flush = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b0) begin miscompares++; $display("FAIL flush_waddr: got req=%b need 0", bus.data_req); end
    cyc();
    idle_inputs();
    mem_op = 4'd5; alu = 32'h6200; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h6200 || bus.data_wr !== 1'b0) begin miscompares++; $display("FAIL flush_waddr_next: got %b/%h/%b need 1/6200/0", bus.data_req, bus.data_addr, bus.data_wr); end
    cyc();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
    cyc();
    $display("flush in wait_addr: request withdrawn, lw 0x6200 issued");
    idle_inputs();
    cyc();
  endtask

  task automatic test_done_hold();
    mem_op = 4'd5; alu = 32'h7000; bus.data_addr_ok = 1'b1;
    cyc();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFEF00D; wbstall = 1'b1;
    @(negedge clk);
    vectors++; if (mem_rdata !== 32'hCAFEF00D || mem_stall !== 1'b0) begin miscompares++; $display("FAIL done_c0: got %h stall=%b need cafef00d/0", mem_rdata, mem_stall); end
    cyc();
    bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
    @(negedge clk);
    vectors++; if (mem_rdata !== 32'hCAFEF00D || mem_stall !== 1'b0 || bus.data_req !== 1'b0) begin miscompares++; $display("FAIL done_hold: got %h stall=%b req=%b need cafef00d/0/0", mem_rdata, mem_stall, bus.data_req); end
    cyc();
    wbstall = 1'b0;
    @(negedge clk);
    vectors++; if (mem_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL done_release: got %h need cafef00d", mem_rdata); end
    cyc();
    mem_op = 4'd1; alu = 32'h7001; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b1 || byte_valid !== 4'b0010 || mem_rdata !== 32'd0) begin miscompares++; $display("FAIL done_next: got req=%b bv=%b rdata=%h need 1/0010/0", bus.data_req, byte_valid, mem_rdata); end
    cyc();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h55;
    cyc();
    $display("lw 0x7000 under wb stall: held cafef00d, then lb 0x7001 issued");
    idle_inputs();
    cyc();
  endtask

  task automatic test_midreset();
    mem_op = 4'd5; alu = 32'h8000; bus.data_addr_ok = 1'b1;
    cyc();
    bus.data_addr_ok = 1'b0; mem_op = 4'd0;
    #2 rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    vectors++; if (mem_rdata !== 32'd0) begin miscompares++; $display("FAIL reset_ignore: got %h need 0", mem_rdata); end
    cyc();
    bus.data_data_ok = 1'b0; mem_op = 4'd5; alu = 32'h8004; bus.data_addr_ok = 1'b1;
    @(negedge clk);
    vectors++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h8004) begin miscompares++; $display("FAIL reset_reissue: got req=%b addr=%h need 1/8004", bus.data_req, bus.data_addr); end
    cyc();
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234;
    @(negedge clk);
    vectors++; if (mem_rdata !== 32'h1234) begin miscompares++; $display("FAIL reset_lw: got %h need 1234", mem_rdata); end
    $display("reset mid-transaction: stale response ignored, lw 0x8004 rdata=%h", mem_rdata);
    cyc();
    idle_inputs();
    cyc();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_store_align();
    test_fault();
    test_llsc();
    test_flush();
    test_done_hold();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
